multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle control unit for the 16-bit Simple RISC datapath; drives the ALU's 3-bit ALUControl and all datapath enables.

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/alu_op_decoder.sv | 28 ++
 rtl/multicycle_ctrl_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit of the 16-bit Simple RISC core:
// opcodes, ALUControl values, datapath mux selects and the FSM state encoding.
// Optional feature macro: DIV_ZERO_TRAP_EN (adds the TRAP state).
package cpu_ctrl_pkg;

    // Opcodes (instr[15:12])
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_DIV = 3'b101;

    // alu_src_a
    localparam logic SRCA_PC  = 1'b0;
    localparam logic SRCA_RS1 = 1'b1;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    // pc_src
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
`ifdef DIV_ZERO_TRAP_EN
        , S_TRAP   = 4'd12
`endif
    } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an R-type opcode to the ALU's 3-bit ALUControl. Pure combinational.
// Non R-type opcodes decode to ADD.
//  opcode       in  OPCODE_W   instruction opcode
//  alu_control  out ALUCTRL_W  ALU operation select
module alu_op_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int ALUCTRL_W = 3
) (
    input  logic [OPCODE_W-1:0]  opcode,
    output logic [ALUCTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (opcode)
            OP_ADD:  alu_control = ALU_ADD;
            OP_SUB:  alu_control = ALU_SUB;
            OP_AND:  alu_control = ALU_AND;
            OP_OR:   alu_control = ALU_OR;
            OP_MUL:  alu_control = ALU_MUL;
            OP_DIV:  alu_control = ALU_DIV;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit Simple RISC datapath. Sequences
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction and handshakes with
// memory over mem_req/mem_ready, with a wait-cycle timeout to bus_error.
// Optional feature macro: DIV_ZERO_TRAP_EN (DIV with zero divisor -> TRAP).
// Ports:
//  clk, rst                     clock, synchronous active-high reset
//  opcode, alu_zero, alu_b_zero IR opcode and ALU status
//  mem_ready / mem_req, mem_we  memory handshake
//  ir_write, pc_write, pc_src   IR / PC control
//  alu_src_a, alu_src_b,
//  alu_control                  ALU operand/operation select
//  reg_write, wb_src            register file writeback
//  halted, illegal_op,
//  bus_error, div_trap          status
//  state_dbg                    current state encoding
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int ALUCTRL_W    = 3,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 alu_zero,
    input  logic                 alu_b_zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 reg_write,
    output logic                 wb_src,
    output logic                 halted,
    output logic                 illegal_op,
    output logic                 bus_error,
    output logic                 div_trap,
    output logic [3:0]           state_dbg
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t             state, next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               bus_error_q;
    logic [ALUCTRL_W-1:0] r_alu_control;
    logic               in_req;
    logic               timeout;

    alu_op_decoder #(
        .OPCODE_W  (OPCODE_W),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_op_decoder (
        .opcode      (opcode),
        .alu_control (r_alu_control)
    );

    // Memory is busy in these states; the wait counter only runs here.
    assign in_req  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Fires on the MEM_WAIT_MAX-th consecutive request cycle without mem_ready.
    assign timeout = in_req && !mem_ready && (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

    // State register, wait counter and sticky bus error
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state <= next_state;
            if (timeout)
                bus_error_q <= 1'b1;
            if (!in_req || mem_ready || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (timeout)        next_state = S_HALT;
                else if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND,
                    OP_OR, OP_MUL, OP_DIV: next_state = S_EXEC_R;
                    OP_ADDI:               next_state = S_EXEC_I;
                    OP_LW, OP_SW:          next_state = S_MEM_ADDR;
                    OP_BEQ:                next_state = S_BRANCH;
                    OP_JMP:                next_state = S_JUMP;
                    OP_HALT:               next_state = S_HALT;
                    default:               next_state = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
`ifdef DIV_ZERO_TRAP_EN
                if (opcode == OP_DIV && alu_b_zero) next_state = S_TRAP;
                else                                next_state = S_WB_ALU;
`else
                next_state = S_WB_ALU;
`endif
            end
            S_EXEC_I:   next_state = S_WB_ALU;
            S_WB_ALU:   next_state = S_FETCH;
            S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (timeout)        next_state = S_HALT;
                else if (mem_ready) next_state = S_WB_MEM;
            end
            S_WB_MEM:   next_state = S_FETCH;
            S_MEM_WR: begin
                if (timeout)        next_state = S_HALT;
                else if (mem_ready) next_state = S_FETCH;
            end
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
`ifdef DIV_ZERO_TRAP_EN
            S_TRAP:     next_state = S_TRAP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

`ifndef DIV_ZERO_TRAP_EN
    // Divisor status only matters when the trap is built in.
    logic unused_alu_b_zero;
    assign unused_alu_b_zero = alu_b_zero;
`endif

    // Output logic. Everything is held at 0 while rst is asserted so the
    // memory port sees no request during reset, even mid-handshake.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_ALU;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        wb_src      = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;
        div_trap    = 1'b0;
        if (!rst) begin
            bus_error = bus_error_q;
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_ONE;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV,
                        OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT: illegal_op = 1'b0;
                        default:                                        illegal_op = 1'b1;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a   = SRCA_RS1;
                    alu_control = r_alu_control;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_MEM_RD: mem_req = 1'b1;
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_src    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = SRCA_RS1;
                    alu_control = ALU_SUB;
                    pc_src      = PC_ALUOUT;
                    pc_write    = alu_zero;
                end
                S_JUMP: begin
                    pc_src   = PC_JUMP;
                    pc_write = 1'b1;
                end
                S_HALT: halted = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                S_TRAP: div_trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks each instruction class through
// its states with hand-written per-cycle expected outputs.
module tb_multicycle_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    typedef logic [17:0] ov_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       alu_zero, alu_b_zero, mem_ready;
    logic       mem_req, mem_we, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_control;
    logic       reg_write, wb_src, halted, illegal_op, bus_error, div_trap;
    logic [3:0] state_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
        .alu_b_zero(alu_b_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .reg_write(reg_write), .wb_src(wb_src),
        .halted(halted), .illegal_op(illegal_op), .bus_error(bus_error),
        .div_trap(div_trap), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    ov_t ov;
    assign ov = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                 alu_control, reg_write, wb_src, halted, illegal_op, bus_error, div_trap};

    function automatic ov_t mk(input bit req, input bit we, input bit irw, input bit pcw,
                               input bit [1:0] psrc, input bit sa, input bit [1:0] sb,
                               input bit [2:0] alu, input bit rw, input bit wb,
                               input bit h, input bit ill, input bit be, input bit dt);
        return {req, we, irw, pcw, psrc, sa, sb, alu, rw, wb, h, ill, be, dt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Check state and all outputs for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st, input ov_t v);
        #1;
        chk({tag, ".state"}, 32'(state_dbg), 32'(st));
        chk({tag, ".out"},   32'(ov),        32'(v));
        @(posedge clk); #1;
    endtask

    ov_t O_ZERO, O_FETCH_RDY, O_FETCH_WT, O_DECODE, O_WB_ALU, O_MEMADDR,
         O_MEMRD, O_WBMEM, O_MEMWR, O_JUMP, O_HALT;

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({tag, ".rst_state"}, 32'(state_dbg), 32'(S_FETCH));
        chk({tag, ".rst_out"},   32'(ov),        32'(O_ZERO));
        rst = 1'b0;
    endtask

    initial begin
        O_ZERO      = mk(0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0,0);
        O_FETCH_RDY = mk(1,0,1,1,2'b00,0,2'b01,3'b000,0,0,0,0,0,0);
        O_FETCH_WT  = mk(1,0,0,0,2'b00,0,2'b01,3'b000,0,0,0,0,0,0);
        O_DECODE    = mk(0,0,0,0,2'b00,0,2'b10,3'b000,0,0,0,0,0,0);
        O_WB_ALU    = mk(0,0,0,0,2'b00,0,2'b00,3'b000,1,0,0,0,0,0);
        O_MEMADDR   = mk(0,0,0,0,2'b00,1,2'b10,3'b000,0,0,0,0,0,0);
        O_MEMRD     = mk(1,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0,0);
        O_WBMEM     = mk(0,0,0,0,2'b00,0,2'b00,3'b000,1,1,0,0,0,0);
        O_MEMWR     = mk(1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0,0);
        O_JUMP      = mk(0,0,0,1,2'b10,0,2'b00,3'b000,0,0,0,0,0,0);
        O_HALT      = mk(0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,0,0,0);

        opcode = OP_ADD; alu_zero = 1'b0; alu_b_zero = 1'b0; mem_ready = 1'b0;
        do_reset("init");
        mem_ready = 1'b1;

        // ADD: FETCH, DECODE, EXEC_R(000), WB_ALU
        opcode = OP_ADD;
        cyc("add.f",  S_FETCH,  O_FETCH_RDY);
        cyc("add.d",  S_DECODE, O_DECODE);
        cyc("add.x",  S_EXEC_R, mk(0,0,0,0,2'b00,1,2'b00,3'b000,0,0,0,0,0,0));
        cyc("add.wb", S_WB_ALU, O_WB_ALU);

        // MUL: ALU control follows opcode
        opcode = OP_MUL;
        cyc("mul.f",  S_FETCH,  O_FETCH_RDY);
        cyc("mul.d",  S_DECODE, O_DECODE);
        cyc("mul.x",  S_EXEC_R, mk(0,0,0,0,2'b00,1,2'b00,3'b100,0,0,0,0,0,0));
        cyc("mul.wb", S_WB_ALU, O_WB_ALU);

        // ADDI
        opcode = OP_ADDI;
        cyc("addi.f",  S_FETCH,  O_FETCH_RDY);
        cyc("addi.d",  S_DECODE, O_DECODE);
        cyc("addi.x",  S_EXEC_I, O_MEMADDR);
        cyc("addi.wb", S_WB_ALU, O_WB_ALU);

        // LW with mem_ready late by 3 cycles: 8 cycles total
        opcode = OP_LW;
        cyc("lw.f",  S_FETCH,    O_FETCH_RDY);
        cyc("lw.d",  S_DECODE,   O_DECODE);
        cyc("lw.a",  S_MEM_ADDR, O_MEMADDR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw.rdw", S_MEM_RD, O_MEMRD);
        mem_ready = 1'b1;
        cyc("lw.rd", S_MEM_RD, O_MEMRD);
        cyc("lw.wb", S_WB_MEM, O_WBMEM);

        // SW zero-wait
        opcode = OP_SW;
        cyc("sw.f", S_FETCH,    O_FETCH_RDY);
        cyc("sw.d", S_DECODE,   O_DECODE);
        cyc("sw.a", S_MEM_ADDR, O_MEMADDR);
        cyc("sw.w", S_MEM_WR,   O_MEMWR);

        // BEQ taken / not taken
        opcode = OP_BEQ; alu_zero = 1'b1;
        cyc("beq1.f", S_FETCH,  O_FETCH_RDY);
        cyc("beq1.d", S_DECODE, O_DECODE);
        cyc("beq1.b", S_BRANCH, mk(0,0,0,1,2'b01,1,2'b00,3'b001,0,0,0,0,0,0));
        alu_zero = 1'b0;
        cyc("beq0.f", S_FETCH,  O_FETCH_RDY);
        cyc("beq0.d", S_DECODE, O_DECODE);
        cyc("beq0.b", S_BRANCH, mk(0,0,0,0,2'b01,1,2'b00,3'b001,0,0,0,0,0,0));

        // JMP
        opcode = OP_JMP;
        cyc("jmp.f", S_FETCH,  O_FETCH_RDY);
        cyc("jmp.d", S_DECODE, O_DECODE);
        cyc("jmp.j", S_JUMP,   O_JUMP);

        // Illegal opcode: pulse in DECODE, straight back to FETCH
        opcode = 4'hC;
        cyc("ill.f", S_FETCH,  O_FETCH_RDY);
        cyc("ill.d", S_DECODE, mk(0,0,0,0,2'b00,0,2'b10,3'b000,0,0,0,1,0,0));
        cyc("ill.r", S_FETCH,  O_FETCH_RDY);
        cyc("ill.n", S_DECODE, mk(0,0,0,0,2'b00,0,2'b10,3'b000,0,0,0,1,0,0));

        // DIV by zero
        opcode = OP_DIV; alu_b_zero = 1'b1;
        cyc("div.f", S_FETCH,  O_FETCH_RDY);
        cyc("div.d", S_DECODE, O_DECODE);
        cyc("div.x", S_EXEC_R, mk(0,0,0,0,2'b00,1,2'b00,3'b101,0,0,0,0,0,0));
`ifdef DIV_ZERO_TRAP_EN
        cyc("div.t0", S_TRAP, mk(0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0,1));
        cyc("div.t1", S_TRAP, mk(0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0,1));
        do_reset("div.rst");
`else
        cyc("div.wb", S_WB_ALU, O_WB_ALU);
`endif
        alu_b_zero = 1'b0;

        // HALT is absorbing
        opcode = OP_HALT;
        cyc("hlt.f",  S_FETCH,  O_FETCH_RDY);
        cyc("hlt.d",  S_DECODE, O_DECODE);
        cyc("hlt.h0", S_HALT,   O_HALT);
        cyc("hlt.h1", S_HALT,   O_HALT);
        do_reset("hlt.rst");

        // Reset mid-handshake with partial wait count, then a full timeout
        opcode = OP_ADD; mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) cyc("pre.wait", S_FETCH, O_FETCH_WT);
        do_reset("mid.rst");
        for (int i = 0; i < 15; i++) cyc("to.wait", S_FETCH, O_FETCH_WT);
        cyc("to.halt0", S_HALT, mk(0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,0,1,0));
        mem_ready = 1'b1;
        cyc("to.halt1", S_HALT, mk(0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,0,1,0));
        do_reset("to.rst");
        cyc("post.f", S_FETCH, O_FETCH_RDY);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
